// File: rtl/braille_seq_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : braille_seq_checker_if                                  |
// | Purpose  : Bundle between the symbol decoder / display logic and    |
// |            the braille_seq_checker sequence comparator.             |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface braille_seq_checker_if #(
  parameter int SYM_W     = 4,
  parameter int SEQ_LEN   = 5,
  parameter int MAX_TRIES = 3
);
  localparam int IDX_W = $clog2(SEQ_LEN + 1);
  localparam int FC_W  = $clog2(MAX_TRIES + 1);

  logic                     valid;
  logic [SYM_W-1:0]         player_sym;
  logic [SEQ_LEN*SYM_W-1:0] exp_seq;
  logic                     unlock;
  logic                     allow;
  logic                     deny;
  logic                     segen;
  logic                     busy;
  logic                     locked;
  logic [IDX_W-1:0]         idx;
  logic [FC_W-1:0]          fail_cnt;
  logic [SEQ_LEN-1:0]       miss_map;

  // Decoder / trainer side: supplies symbols, watches the verdicts.
  modport master (
    output valid, player_sym, exp_seq, unlock,
    input  allow, deny, segen, busy, locked, idx, fail_cnt, miss_map
  );

  // Checker side.
  modport slave (
    input  valid, player_sym, exp_seq, unlock,
    output allow, deny, segen, busy, locked, idx, fail_cnt, miss_map
  );
endinterface
`default_nettype wire

// File: rtl/braille_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : braille_seq_checker                                     |
// | Purpose  : Compares a SEQ_LEN-symbol player entry against a latched |
// |            expected sequence; inter-symbol timeout, consecutive-    |
// |            failure lockout, allow/deny pulses and progress index.   |
// | Options  : define MISMATCH_LOG_EN to build the per-position         |
// |            mismatch map (miss_map); otherwise miss_map reads 0.     |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module braille_seq_checker #(
  parameter int SYM_W       = 4,
  parameter int SEQ_LEN     = 5,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  braille_seq_checker_if.slave bus
);
  localparam int IDX_W = $clog2(SEQ_LEN + 1);
  localparam int FC_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VERIFY  = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t                   state, state_nx;
  logic [IDX_W-1:0]         idx_q, idx_nx;
  logic [FC_W-1:0]          fail_q, fail_nx, fail_base;
  logic [TMR_W-1:0]         timer_q, timer_nx;
  logic [SEQ_LEN*SYM_W-1:0] shadow_q, shadow_nx;
  logic                     mm_q, mm_nx;
  logic                     allow_q, allow_nx;
  logic                     deny_q, deny_nx;
  logic                     segen_q, segen_nx;
  logic                     fail_evt;
  logic                     sym_neq;
  logic [SYM_W-1:0]         cur_sym;
`ifdef MISMATCH_LOG_EN
  logic [SEQ_LEN-1:0]       miss_q, miss_nx;
`endif

  // State and datapath registers; reset clears every piece of attempt state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      shadow_q <= '0;
      mm_q     <= 1'b0;
      allow_q  <= 1'b0;
      deny_q   <= 1'b0;
      segen_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      idx_q    <= idx_nx;
      fail_q   <= fail_nx;
      timer_q  <= timer_nx;
      shadow_q <= shadow_nx;
      mm_q     <= mm_nx;
      allow_q  <= allow_nx;
      deny_q   <= deny_nx;
      segen_q  <= segen_nx;
    end
  end

  // Next-state, comparison, timeout and failure accounting.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx_q;
    timer_nx  = timer_q;
    shadow_nx = shadow_q;
    mm_nx     = mm_q;
    allow_nx  = 1'b0;
    deny_nx   = 1'b0;
    segen_nx  = segen_q;
    fail_evt  = 1'b0;
    // unlock clears the failure count in any state.
    fail_base = bus.unlock ? '0 : fail_q;
    fail_nx   = fail_base;
`ifdef MISMATCH_LOG_EN
    miss_nx   = miss_q;
`endif

    // Shadow symbol at the current position.
    cur_sym = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) cur_sym = shadow_q[i*SYM_W +: SYM_W];
    end
    sym_neq = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.valid) begin
          // First symbol compares against the live input; the shadow copy
          // protects the rest of the attempt from exp_seq changes.
          sym_neq   = (bus.player_sym != bus.exp_seq[SYM_W-1:0]);
          shadow_nx = bus.exp_seq;
          mm_nx     = sym_neq;
          segen_nx  = 1'b1;
          idx_nx    = IDX_W'(1);
          timer_nx  = '0;
          state_nx  = (SEQ_LEN == 1) ? S_VERIFY : S_COLLECT;
`ifdef MISMATCH_LOG_EN
          miss_nx    = '0;
          miss_nx[0] = sym_neq;
`endif
        end
      end

      S_COLLECT: begin
        if (bus.valid) begin
          // A symbol in the expiry cycle still counts.
          sym_neq  = (bus.player_sym != cur_sym);
          mm_nx    = mm_q | sym_neq;
          idx_nx   = idx_q + IDX_W'(1);
          timer_nx = '0;
          if (idx_nx == IDX_W'(SEQ_LEN)) state_nx = S_VERIFY;
`ifdef MISMATCH_LOG_EN
          for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx_q == IDX_W'(i)) miss_nx[i] = sym_neq;
          end
`endif
        end else if (TIMEOUT_CYC != 0) begin
          if (timer_q == TMR_W'(TIMEOUT_CYC)) fail_evt = 1'b1;
          else                                timer_nx = timer_q + TMR_W'(1);
        end
      end

      S_VERIFY: begin
        if (mm_q) begin
          fail_evt = 1'b1;
        end else begin
          allow_nx = 1'b1;
          fail_nx  = '0;
          idx_nx   = '0;
          state_nx = S_IDLE;
        end
      end

      S_LOCKED: begin
        // Symbols are dropped here, even alongside unlock.
        if (bus.unlock) begin
          fail_nx  = '0;
          state_nx = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase

    // Common failure path for mismatch verdicts and timeouts.
    if (fail_evt) begin
      deny_nx  = 1'b1;
      fail_nx  = fail_base + FC_W'(1);
      idx_nx   = '0;
      timer_nx = '0;
      mm_nx    = 1'b0;
      state_nx = (fail_nx == FC_W'(MAX_TRIES)) ? S_LOCKED : S_IDLE;
    end
  end

`ifdef MISMATCH_LOG_EN
  // Per-position mismatch history, kept until the next attempt starts.
  always_ff @(posedge clk) begin
    if (!rst) miss_q <= '0;
    else      miss_q <= miss_nx;
  end
  assign bus.miss_map = miss_q;
`else
  assign bus.miss_map = '0;
`endif

  assign bus.allow    = allow_q;
  assign bus.deny     = deny_q;
  assign bus.segen    = segen_q;
  assign bus.busy     = (state == S_COLLECT) || (state == S_VERIFY);
  assign bus.locked   = (state == S_LOCKED);
  assign bus.idx      = idx_q;
  assign bus.fail_cnt = fail_q;

endmodule
`default_nettype wire

// File: doc/braille_seq_checker.md
Name: braille_seq_checker

Overview:
- Parametrised successor to the trainer's five-letter access controller.
- Compares a player-entered sequence of SEQ_LEN symbols, each SYM_W bits wide, against an expected sequence.
- Adds four things the previous block lacked: an inter-symbol timeout, a consecutive-failure counter with lockout, explicit allow/deny pulses, and a progress index.
- Sits between the keypad/Braille-cell decoder (valid, player_sym) and the display/reward logic (allow, deny, segen).

Parameters:
- SYM_W, 4, bits per symbol.
- SEQ_LEN, 5, symbols per attempt (>=1).
- MAX_TRIES, 3, consecutive failed attempts before lockout (>=1).
- TIMEOUT_CYC, 16, max idle cycles between accepted symbols within an attempt; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- valid  in  1  player_sym is valid this cycle (one symbol per high cycle).
- player_sym  in  SYM_W  entered symbol.
- exp_seq  in  SEQ_LEN*SYM_W  expected sequence; symbol i is at bits [i*SYM_W +: SYM_W].
- unlock  in  1  clears lockout and the failure count.
- allow  out  1  one-cycle pulse: attempt fully matched.
- deny  out  1  one-cycle pulse: attempt failed (mismatch or timeout).
- segen  out  1  sticky; set on the first symbol ever accepted after reset.
- busy  out  1  high while state is COLLECT or VERIFY.
- locked  out  1  high in LOCKED.
- idx  out  $clog2(SEQ_LEN+1)  symbols accepted in the current attempt.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures.
- miss_map  out  SEQ_LEN  per-position mismatch flags (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - allow, deny, segen, busy, locked, idx, fail_cnt, miss_map, internal mismatch flag and timer all 0.
  - Reset applies mid-attempt and mid-lockout; no residual state survives.
- IDLE:
  - valid=1: latch exp_seq into an internal shadow register, compare player_sym to symbol 0, set the mismatch flag if unequal, set segen=1, set idx=1.
  - Then go to COLLECT, or directly to VERIFY if SEQ_LEN==1.
  - exp_seq changes after this latch do not affect the attempt.
- COLLECT:
  - valid=1: compare to shadow symbol idx, OR any mismatch into the flag, idx++, reset the timer.
  - When idx reaches SEQ_LEN, go to VERIFY.
  - valid=0: timer++. If TIMEOUT_CYC!=0 and the timer reaches TIMEOUT_CYC, the attempt aborts as a failure: deny pulse on the next edge, same fail handling as in VERIFY, return to IDLE or LOCKED.
  - valid and timer expiry in the same cycle: valid wins, no timeout.
- VERIFY (one cycle; valid ignored):
  - Flag clear: allow=1 next cycle, fail_cnt=0.
  - Flag set: deny=1 next cycle, fail_cnt++.
  - Next state is LOCKED if fail_cnt reaches MAX_TRIES, otherwise IDLE. idx returns to 0.
- Latency: if the last symbol is sampled at edge k, allow/deny are high from edge k+1 to edge k+2. A valid during that pulse cycle (state IDLE) starts a new attempt.
- LOCKED:
  - locked=1; valid ignored.
  - unlock=1 -> IDLE, fail_cnt=0, locked=0 on the next edge.
  - unlock together with valid: the valid is dropped.
  - unlock outside LOCKED only clears fail_cnt.
- allow and deny are never high together. No output is combinational from inputs.

Optional Feature:
- Macro MISMATCH_LOG_EN.
- Defined: miss_map[i] is set when position i mismatches. miss_map clears at the start of each attempt and holds after deny until the next attempt begins. Positions never reached because of a timeout stay 0.
- Undefined: miss_map is tied to 0 and no storage is built; all other behaviour is identical.

Test Plan (defaults: SYM_W=4, SEQ_LEN=5, MAX_TRIES=3, TIMEOUT_CYC=16):
1. exp_seq symbols 1,2,3,4,5; enter 1,2,3,4,5 on consecutive cycles -> allow single pulse 2 edges after last valid, deny=0, fail_cnt=0, segen=1, idx back to 0.
2. Enter 1,2,9,4,5 -> deny pulse, fail_cnt=1; with MISMATCH_LOG_EN, miss_map=5'b00100.
3. Three wrong attempts back-to-back -> fail_cnt=3, locked=1, further valid ignored (idx stays 0); pulse unlock -> locked=0, fail_cnt=0; a correct attempt then gives allow.
4. Enter 1,2 then 16 idle cycles -> deny on the timeout, fail_cnt=1; a repeat where valid arrives exactly in the expiry cycle -> no deny, attempt continues.
5. Change exp_seq to all 0 after the first symbol, then finish 1..5 -> allow still asserted because of the shadow latch.
6. Assert rst=0 at idx=3 with fail_cnt=2 -> all outputs 0 next cycle including segen; the following full correct attempt gives allow.
